aes_stream_cipher: RTL and testbench
====================================

# aes_stream_cipher

Parametrised byte-stream cipher, successor to the single-byte AES_cipher. Processes LANES bytes per beat with a KEY_BYTES-byte rotating key, byte-level ciphertext chaining, selectable encrypt/decrypt mode and full valid/ready backpressure on both sides. Sits between the message source and the output sink in the HES datapath; a 2-entry output buffer decouples the sink.

## Interface
- LANES, 1: bytes per beat, 1..16
- KEY_BYTES, 1: key length in bytes, 1..16
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- new_message  in  1  start of message: latch key and mode, clear chain and key index
- key  in  8*KEY_BYTES  key; byte b = key[8b+7:8b]; sampled only when new_message=1
- decrypt  in  1  mode, 0 = encrypt, 1 = decrypt; sampled only when new_message=1
- data_in  in  8*LANES  input beat; lane 0 = data_in[7:0] = earliest byte
- valid_in  in  1  data_in valid
- ready_in  out  1  block can accept a beat this cycle
- data_out  out  8*LANES  result beat, same lane order
- valid_out  out  1  data_out valid
- ready_out  in  1  sink accepts data_out this cycle

## Operation
- Accept: valid_in & ready_in at a rising edge. Output handshake: valid_out & ready_out.
- Registers: key_q, mode_q, chain_q (8 bit), kidx_q (0..KEY_BYTES-1), 2-entry output buffer.
- Per lane j (serial within the beat): k = key_q byte (kidx_q+j) mod KEY_BYTES; prev = chain_q for j=0, else ciphertext byte of lane j-1.
  - Encrypt: c = SBOX(p ^ k ^ prev); output c.
  - Decrypt: p = INV_SBOX(c) ^ k ^ prev; output p.
  - SBOX/INV_SBOX are the FIPS-197 AES tables.
- On accept: chain_q <= ciphertext byte of lane LANES-1 (computed c in encrypt, input c in decrypt); kidx_q <= (kidx_q+LANES) mod KEY_BYTES; result pushed into the buffer.
- new_message=1: key_q <= key, mode_q <= decrypt, chain_q <= 0, kidx_q <= 0. Independent of valid_in; takes no handshake.
- new_message and an accepted beat in the same cycle: the beat uses the new key, new mode, chain 0, index 0; state afterwards reflects that beat.
- new_message does not flush the output buffer; queued results still drain.
- Reset clears key_q, chain_q, kidx_q, buffer; mode_q = encrypt.

## Timing
- Reset values: ready_in=1 (buffer empty), valid_out=0, data_out=0.
- Latency: beat accepted at edge N is on data_out with valid_out=1 in the cycle after edge N.
- Throughput: one beat per cycle while ready_out=1.
- ready_in = buffer occupancy < 2, taken from registered occupancy only; no combinational path ready_out -> ready_in.
- Buffer full (2): ready_in=0; valid_in ignored, no state change.
- Simultaneous push and pop at occupancy 2 is impossible (ready_in=0); at 1: occupancy stays 1, order preserved.
- valid_out and data_out stable while valid_out=1 and ready_out=0.
- kidx wraps mod KEY_BYTES, including LANES > KEY_BYTES and non-divisible cases.
- Reset mid-message: all in-flight and buffered data discarded next cycle; valid_out=0.

## Structure
- Package aes_stream_pkg: byte_t typedef, SBOX and INV_SBOX 256-entry constant arrays, sbox/inv_sbox functions.
- Sub-module aes_stream_out_fifo: 2-entry FIFO, parametrised width, with full/empty/count; reset clears it.
- Top: lane chain (generate loop), key/chain/index registers, handshake glue.

## Test plan
- LANES=1, KEY_BYTES=1, key 0x00, encrypt, bytes 00,00 -> outputs 63, FB; ready_out=1 throughout, one result per cycle, 1-cycle latency.
- Same config, key 0x53, encrypt, byte 00 -> ED; then new_message with key 0x00, byte 01 -> 7C (chain cleared).
- Decrypt, key 0x00, bytes 63, FB -> 00, 00; random 256-byte round trip encrypt→decrypt, KEY_BYTES=3, LANES=4 -> identity.
- LANES=2, KEY_BYTES=1, key 0x00, beat 0x0000 -> 0xFB63 (lane 0 = 63, lane 1 = FB), identical to LANES=1 stream.
- Backpressure: hold ready_out=0 with valid_in=1 -> exactly 2 beats accepted, ready_in=0 next cycle, data_out stable; release -> drained in order, no loss or duplication.
- Reset asserted with 2 buffered beats -> next cycle valid_out=0, ready_in=1; following encrypt of 00 with key 00 after new_message -> 63.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared types and FIPS-197 S-box tables for the AES byte-stream cipher.
package aes_stream_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic byte_t sbox(input byte_t x);
    return SBOX[x];
  endfunction

  function automatic byte_t inv_sbox(input byte_t x);
    return INV_SBOX[x];
  endfunction

endpackage

// File: rtl/aes_stream_out_fifo.sv
// Two-entry output FIFO decoupling the cipher result from the sink.
module aes_stream_out_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
      end
      wr_ptr_q <= wr_ptr_q ^ do_push;
      rd_ptr_q <= rd_ptr_q ^ do_pop;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/aes_stream_cipher.sv
// Multi-lane AES S-box stream cipher with rotating key, byte chaining and a
// two-entry output buffer.
module aes_stream_cipher
  import aes_stream_pkg::*;
#(
  parameter int unsigned LANES     = 1,
  parameter int unsigned KEY_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_message,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic                   decrypt,
  input  logic [8*LANES-1:0]     data_in,
  input  logic                   valid_in,
  output logic                   ready_in,
  output logic [8*LANES-1:0]     data_out,
  output logic                   valid_out,
  input  logic                   ready_out
);

  // One spare bit so (index + step) never overflows before the wrap.
  localparam int unsigned KidxW     = $clog2(KEY_BYTES) + 1;
  localparam int unsigned LaneStepI = LANES % KEY_BYTES;
  localparam logic [KidxW-1:0] KeyBytesV = KEY_BYTES[KidxW-1:0];
  localparam logic [KidxW-1:0] LaneStep  = LaneStepI[KidxW-1:0];

  // Both operands are below KEY_BYTES, so one conditional subtract wraps.
  function automatic logic [KidxW-1:0] wrap_add(input logic [KidxW-1:0] a,
                                                input logic [KidxW-1:0] b);
    logic [KidxW-1:0] sum;
    sum = a + b;
    return (sum >= KeyBytesV) ? sum - KeyBytesV : sum;
  endfunction

  logic [8*KEY_BYTES-1:0] key_q, key_d, eff_key;
  logic                   mode_q, mode_d, eff_mode;
  byte_t                  chain_q, chain_d, eff_chain;
  logic [KidxW-1:0]       kidx_q, kidx_d, eff_kidx;

  byte_t                  prev [LANES+1];
  logic [8*LANES-1:0]     result;
  logic                   accept;
  logic                   fifo_full, fifo_empty;
  logic [1:0]             fifo_count;

  // A beat arriving with new_message already sees the fresh message state.
  assign eff_key   = new_message ? key : key_q;
  assign eff_mode  = new_message ? decrypt : mode_q;
  assign eff_chain = new_message ? 8'h00 : chain_q;
  assign eff_kidx  = new_message ? '0 : kidx_q;

  assign prev[0] = eff_chain;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    localparam int unsigned JModI = j % KEY_BYTES;
    localparam logic [KidxW-1:0] JMod = JModI[KidxW-1:0];

    logic [KidxW-1:0] sel;
    byte_t            k, b_in, enc;

    assign sel  = wrap_add(eff_kidx, JMod);
    assign k    = 8'(eff_key >> {sel, 3'b000});
    assign b_in = data_in[8*j +: 8];
    assign enc  = sbox(b_in ^ k ^ prev[j]);

    assign result[8*j +: 8] = eff_mode ? (inv_sbox(b_in) ^ k ^ prev[j]) : enc;
    // Chaining always follows the ciphertext side, whatever the mode.
    assign prev[j+1]        = eff_mode ? b_in : enc;
  end

  assign ready_in  = ~fifo_full;
  assign valid_out = (fifo_count != 2'd0);
  assign accept    = valid_in & ready_in;

  always_comb begin
    key_d   = key_q;
    mode_d  = mode_q;
    chain_d = chain_q;
    kidx_d  = kidx_q;
    if (new_message) begin
      key_d   = key;
      mode_d  = decrypt;
      chain_d = 8'h00;
      kidx_d  = '0;
    end
    if (accept) begin
      chain_d = prev[LANES];
      kidx_d  = wrap_add(eff_kidx, LaneStep);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q   <= '0;
      mode_q  <= 1'b0;
      chain_q <= 8'h00;
      kidx_q  <= '0;
    end else begin
      key_q   <= key_d;
      mode_q  <= mode_d;
      chain_q <= chain_d;
      kidx_q  <= kidx_d;
    end
  end

  aes_stream_out_fifo #(
    .Width(8*LANES)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (result),
    .pop   (ready_out & ~fifo_empty),
    .rdata (data_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_aes_stream_cipher.sv
// Bench for aes_stream_cipher: three configurations checked against an
// arithmetic S-box model plus directed literal vectors.
module tb_aes_stream_cipher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [127:0] din  [3];
  logic [127:0] keyv [3];
  logic [2:0]   vin, nm, dec, rout;
  wire  [2:0]   rin, vout;
  wire  [7:0]   a_dout;
  wire  [15:0]  b_dout;
  wire  [31:0]  c_dout;
  logic [127:0] dout [3];

  assign dout[0] = {120'b0, a_dout};
  assign dout[1] = {112'b0, b_dout};
  assign dout[2] = {96'b0, c_dout};

  aes_stream_cipher #(.LANES(1), .KEY_BYTES(1)) dut_a (
    .clk(clk), .reset(reset), .new_message(nm[0]), .key(keyv[0][7:0]),
    .decrypt(dec[0]), .data_in(din[0][7:0]), .valid_in(vin[0]), .ready_in(rin[0]),
    .data_out(a_dout), .valid_out(vout[0]), .ready_out(rout[0])
  );

  aes_stream_cipher #(.LANES(2), .KEY_BYTES(1)) dut_b (
    .clk(clk), .reset(reset), .new_message(nm[1]), .key(keyv[1][7:0]),
    .decrypt(dec[1]), .data_in(din[1][15:0]), .valid_in(vin[1]), .ready_in(rin[1]),
    .data_out(b_dout), .valid_out(vout[1]), .ready_out(rout[1])
  );

  aes_stream_cipher #(.LANES(4), .KEY_BYTES(3)) dut_c (
    .clk(clk), .reset(reset), .new_message(nm[2]), .key(keyv[2][23:0]),
    .decrypt(dec[2]), .data_in(din[2][31:0]), .valid_in(vin[2]), .ready_in(rin[2]),
    .data_out(c_dout), .valid_out(vout[2]), .ready_out(rout[2])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model S-box derived from GF(2^8) inversion plus the affine map.
  logic [7:0] m_sbox [256];
  logic [7:0] m_inv  [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic void build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      m_sbox[x] = s;
      m_inv[s]  = 8'(x);
    end
  endfunction

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic int kb_of(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  logic [7:0]   m_key  [3][16];
  logic         m_mode [3];
  logic [7:0]   m_chain[3];
  int           m_kidx [3];
  logic [127:0] sb     [3][2];
  int           sb_cnt [3];

  function automatic logic [127:0] model_beat(input int d, input logic [127:0] x_in);
    logic [127:0] r;
    logic [7:0]   prev, k, x, c;
    r = '0;
    prev = m_chain[d];
    for (int j = 0; j < lanes_of(d); j++) begin
      k = m_key[d][(m_kidx[d] + j) % kb_of(d)];
      x = x_in[8*j +: 8];
      if (!m_mode[d]) begin
        c = m_sbox[x ^ k ^ prev];
        r[8*j +: 8] = c;
      end else begin
        c = x;
        r[8*j +: 8] = m_inv[c] ^ k ^ prev;
      end
      prev = c;
    end
    m_chain[d] = prev;
    m_kidx[d]  = (m_kidx[d] + lanes_of(d)) % kb_of(d);
    return r;
  endfunction

  // Compare process: check current outputs, then advance the model across the next edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic accepted, popped;
      if (reset) begin
        sb_cnt[d]  = 0;
        m_mode[d]  = 1'b0;
        m_chain[d] = 8'h00;
        m_kidx[d]  = 0;
        for (int b = 0; b < 16; b++) m_key[d][b] = 8'h00;
      end else begin
        check($sformatf("ready_in[%0d]", d), 128'(rin[d]), 128'(sb_cnt[d] < 2));
        check($sformatf("valid_out[%0d]", d), 128'(vout[d]), 128'(sb_cnt[d] > 0));
        if (sb_cnt[d] > 0) check($sformatf("data_out[%0d]", d), dout[d], sb[d][0]);
        accepted = vin[d] && (sb_cnt[d] < 2);
        popped   = (sb_cnt[d] > 0) && rout[d];
        if (nm[d]) begin
          for (int b = 0; b < 16; b++) m_key[d][b] = keyv[d][8*b +: 8];
          m_mode[d]  = dec[d];
          m_chain[d] = 8'h00;
          m_kidx[d]  = 0;
        end
        if (popped) begin
          sb[d][0] = sb[d][1];
          sb_cnt[d]--;
        end
        if (accepted) begin
          sb[d][sb_cnt[d]] = model_beat(d, din[d]);
          sb_cnt[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0]  pt [64];
  logic [31:0]  ct [64];
  logic [7:0]   seqv [6];
  int           idx;
  logic         acc;

  initial begin
    build_tables();
    reset = 1'b1;
    vin = '0; nm = '0; dec = '0; rout = '0;
    for (int d = 0; d < 3; d++) begin
      din[d] = '0;
      keyv[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("model sbox 00", 128'(m_sbox[8'h00]), 128'(8'h63));
    check("model sbox 53", 128'(m_sbox[8'h53]), 128'(8'hed));
    check("model inv 63", 128'(m_inv[8'h63]), 128'(8'h00));
    check("reset ready_in", 128'(rin[0]), 128'(1'b1));
    check("reset valid_out", 128'(vout[0]), 128'(1'b0));
    check("reset data_out", 128'(a_dout), 128'(8'h00));

    // Encrypt 00,00 with key 00.
    nm[0] = 1'b1; keyv[0] = '0; dec[0] = 1'b0; din[0] = '0; vin[0] = 1'b1; rout[0] = 1'b1;
    tick();
    nm[0] = 1'b0; din[0] = '0;
    check("enc 00 first", 128'(a_dout), 128'(8'h63));
    tick();
    vin[0] = 1'b0;
    check("enc 00 second", 128'(a_dout), 128'(8'hfb));
    tick();

    // Key 53, then standalone new_message clears the chain.
    nm[0] = 1'b1; keyv[0] = 128'h53; din[0] = '0; vin[0] = 1'b1;
    tick();
    nm[0] = 1'b0; vin[0] = 1'b0;
    check("enc key53", 128'(a_dout), 128'(8'hed));
    tick();
    nm[0] = 1'b1; keyv[0] = '0;
    tick();
    nm[0] = 1'b0; din[0] = 128'h01; vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    check("enc 01 fresh chain", 128'(a_dout), 128'(8'h7c));
    tick();

    // Decrypt 63,FB with key 00.
    nm[0] = 1'b1; dec[0] = 1'b1; din[0] = 128'h63; vin[0] = 1'b1;
    tick();
    nm[0] = 1'b0; din[0] = 128'hfb;
    check("dec 63", 128'(a_dout), 128'(8'h00));
    tick();
    vin[0] = 1'b0;
    check("dec fb", 128'(a_dout), 128'(8'h00));
    tick();

    // Two lanes, one key byte.
    nm[1] = 1'b1; keyv[1] = '0; dec[1] = 1'b0; din[1] = '0; vin[1] = 1'b1; rout[1] = 1'b1;
    tick();
    nm[1] = 1'b0; vin[1] = 1'b0;
    check("two lane 0000", 128'(b_dout), 128'(16'hfb63));
    tick();

    // Round trip, 4 lanes, 3-byte key, 256 bytes.
    keyv[2] = 128'($urandom_range(0, 32'h00ff_ffff));
    rout[2] = 1'b1;
    for (int i = 0; i < 64; i++) pt[i] = $urandom;
    for (int i = 0; i < 64; i++) begin
      nm[2] = (i == 0); dec[2] = 1'b0; din[2] = 128'(pt[i]); vin[2] = 1'b1;
      tick();
      ct[i] = c_dout;
    end
    nm[2] = 1'b0; vin[2] = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) begin
      nm[2] = (i == 0); dec[2] = 1'b1; din[2] = 128'(ct[i]); vin[2] = 1'b1;
      tick();
      check($sformatf("roundtrip beat %0d", i), 128'(c_dout), 128'(pt[i]));
    end
    nm[2] = 1'b0; vin[2] = 1'b0;
    tick();

    // Backpressure: only two beats fit while the sink stalls.
    seqv[0] = 8'h10; seqv[1] = 8'h11; seqv[2] = 8'h12;
    seqv[3] = 8'h13; seqv[4] = 8'h14; seqv[5] = 8'h15;
    nm[0] = 1'b1; keyv[0] = '0; dec[0] = 1'b0; rout[0] = 1'b0; vin[0] = 1'b1;
    idx = 0;
    repeat (5) begin
      din[0] = 128'(seqv[idx]);
      acc = rin[0];
      tick();
      nm[0] = 1'b0;
      if (acc) idx++;
    end
    check("bp beats accepted", 128'(idx), 128'(2));
    check("bp ready_in low", 128'(rin[0]), 128'(1'b0));
    check("bp head held", 128'(a_dout), 128'(8'hca));
    tick();
    check("bp head still held", 128'(a_dout), 128'(8'hca));
    vin[0] = 1'b0; rout[0] = 1'b1;
    tick();
    check("bp drain second", 128'(a_dout), 128'(8'hb9));
    tick();
    check("bp drained", 128'(vout[0]), 128'(1'b0));

    // Reset with two buffered beats.
    nm[0] = 1'b1; rout[0] = 1'b0; din[0] = '0; vin[0] = 1'b1;
    tick();
    nm[0] = 1'b0;
    tick();
    check("pre-reset valid_out", 128'(vout[0]), 128'(1'b1));
    reset = 1'b1; vin[0] = 1'b0;
    tick();
    check("mid reset valid_out", 128'(vout[0]), 128'(1'b0));
    check("mid reset ready_in", 128'(rin[0]), 128'(1'b1));
    reset = 1'b0;
    nm[0] = 1'b1; keyv[0] = '0; dec[0] = 1'b0; din[0] = '0; vin[0] = 1'b1; rout[0] = 1'b1;
    tick();
    nm[0] = 1'b0; vin[0] = 1'b0;
    check("post reset enc", 128'(a_dout), 128'(8'h63));
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
